// File: rtl/eth_wb_pkg.sv
// Shared types and default widths for the ethmac Wishbone register master.
package eth_wb_pkg;

  localparam int ETH_WB_AW = 12;
  localparam int ETH_WB_DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic                   we;
    logic [ETH_WB_AW-1:0]   addr;
    logic [ETH_WB_DW-1:0]   wdata;
    logic [ETH_WB_DW/8-1:0] sel;
  } eth_wb_cmd_t;

endpackage

// File: rtl/eth_wb_timeout.sv
// Bus-cycle watchdog: counts BUS cycles and flags the cycle in which the
// count reaches TIMEOUT_CYC-1.
module eth_wb_timeout #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire_o = en_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/eth_wb_reg_master.sv
// Single-outstanding Wishbone classic master for the ethmac register/BD port.
// Optional bus watchdog enabled by defining ETH_WB_TIMEOUT_EN.
module eth_wb_reg_master
  import eth_wb_pkg::*;
#(
  parameter int AW          = ETH_WB_AW,
  parameter int DW          = ETH_WB_DW,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  input  logic [DW/8-1:0] cmd_sel,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  output logic          busy
);

  state_e          state_q;
  logic [AW-1:0]   adr_q;
  logic [DW-1:0]   dat_q;
  logic [DW/8-1:0] sel_q;
  logic            we_q;
  logic            cyc_q;
  logic            rsp_valid_q;
  logic [DW-1:0]   rsp_rdata_q;
  logic            rsp_err_q;

  logic cmd_fire;
  logic timeout;
  logic bus_done;
  logic bus_err;
  logic rd_ok;

  assign cmd_fire = (state_q == IDLE) && cmd_valid;

`ifdef ETH_WB_TIMEOUT_EN
  eth_wb_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (cmd_fire),
    .en_i     (state_q == BUS),
    .expire_o (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // A real ack in the expiry cycle still wins over the watchdog.
  assign bus_done = cyc_q && (wb_ack_i || wb_err_i || timeout);
  assign bus_err  = wb_err_i || (timeout && !wb_ack_i);
  assign rd_ok    = !we_q && wb_ack_i && !wb_err_i;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_fire) begin
            adr_q   <= cmd_addr;
            dat_q   <= cmd_we ? cmd_wdata : '0;
            sel_q   <= cmd_sel;
            we_q    <= cmd_we;
            cyc_q   <= 1'b1;
            state_q <= BUS;
          end
        end
        BUS: begin
          if (bus_done) begin
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= bus_err;
            rsp_rdata_q <= rd_ok ? wb_dat_i : '0;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = sel_q;
  assign wb_we_o   = we_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;

endmodule
